// File: rtl/asip_pkg.sv
// Shared types and constants for the vector ASIP pipeline.
// Instruction width, special encodings and the fetch FSM state type.
package asip_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag.
// Priority bubble > hold > load; a bubble leaves the stored PC untouched.
module fetch_if_id_reg
    import asip_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               bubble_i,
    input  logic               hold_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (hold_i) begin
            instr_d = instr_q;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM (run/halt) and the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds a saturating fetch_count output.
module fetch_stage
    import asip_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write_en,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ifid_load, ifid_bubble, ifid_hold;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_hold   = 1'b0;
        unique case (state_q)
            FETCH_RUN: begin
                if (branch_taken) begin
                    pc_d        = branch_target;
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (pc_write_en) begin
                        pc_d = pc_q + 1'b1;
                    end
                end else if (!pc_write_en) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    // HALT word is latched as a real instruction but the PC parks on it.
                    if (imem_rdata == HALT_INSTR) begin
                        state_d = FETCH_HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            FETCH_HALT: begin
                ifid_bubble = 1'b1;
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id (
        .clk_i    (clk),
        .reset_i  (reset),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .hold_i   (ifid_hold),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q),
        .instr_o  (instruction),
        .pc_o     (pc_out),
        .valid_o  (valid)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == FETCH_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (ifid_load && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected IF/ID state per edge.
// Covers reset, fetch, stall, branch, flush, PC wrap, HALT and reset mid-stall.
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
        logic        valid;
        logic [7:0]  addr;
        logic        halted;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       bt;
        logic [7:0] tgt;
        logic       fl;
        logic       pwe;
        obs_t       e;
    } row_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write_en;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [7:0]  pc_out;
    logic        valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic [15:0] mem [256];
    obs_t        sb [$];
    int          checks   = 0;
    int          failures = 0;

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write_en   (pc_write_en),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .valid         (valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    function automatic row_t mk(logic rst, logic bt, logic [7:0] tgt, logic fl, logic pwe,
                                logic [15:0] i, logic [7:0] p, logic v, logic [7:0] a,
                                logic h);
        row_t r;
        r.rst = rst; r.bt = bt; r.tgt = tgt; r.fl = fl; r.pwe = pwe;
        r.e   = '{instr: i, pc: p, valid: v, addr: a, halted: h};
        return r;
    endfunction

    // Drive one row, record its expectation, then sample 1 time unit after the edge.
    task automatic apply(input row_t r);
        reset         = r.rst;
        branch_taken  = r.bt;
        branch_target = r.tgt;
        flush         = r.fl;
        pc_write_en   = r.pwe;
        sb.push_back(r.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        apply(mk(1, 0, 8'h00, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0));
        apply(mk(1, 0, 8'h00, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0));
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            if (k == 1) begin
                o = {instruction, pc_out, valid, imem_addr, halted};
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL reset: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                             o.instr, o.pc, o.valid, o.addr, o.halted,
                             e.instr, e.pc, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_normal();
        obs_t o, e;
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 0, 8'h00, 0, 1, 16'h1000 + 16'(k), 8'(k), 1, 8'(k + 1), 0));
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL normal[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
        end
    endtask

    task automatic test_stall();
        obs_t o, e;
        row_t rows[$];
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1004, 8'h04, 1, 8'h05, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 0, 16'h1004, 8'h04, 1, 8'h05, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 0, 16'h1004, 8'h04, 1, 8'h05, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1005, 8'h05, 1, 8'h06, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1006, 8'h06, 1, 8'h07, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
        end
    endtask

    task automatic test_branch_flush();
        obs_t o, e;
        row_t rows[$];
        // Branch wins over a simultaneous stall and flush.
        rows.push_back(mk(0, 1, 8'h40, 1, 0, 16'h0000, 8'h06, 0, 8'h40, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1040, 8'h40, 1, 8'h41, 0));
        rows.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0000, 8'h40, 0, 8'h42, 0));
        rows.push_back(mk(0, 0, 8'h00, 1, 0, 16'h0000, 8'h40, 0, 8'h42, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1042, 8'h42, 1, 8'h43, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL branch_flush[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t o, e;
        row_t rows[$];
        rows.push_back(mk(0, 1, 8'hFE, 0, 1, 16'h0000, 8'h42, 0, 8'hFE, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h10FE, 8'hFE, 1, 8'hFF, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h10FF, 8'hFF, 1, 8'h00, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1000, 8'h00, 1, 8'h01, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wrap[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
        end
    endtask

    task automatic test_halt();
        obs_t o, e;
        row_t rows[$];
        mem[3] = 16'hFFFF;
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1001, 8'h01, 1, 8'h02, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1002, 8'h02, 1, 8'h03, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'hFFFF, 8'h03, 1, 8'h03, 1));
        // While halted, flush and stall inputs must have no effect.
        for (int k = 0; k < 5; k++) begin
            rows.push_back(mk(0, 0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              16'h0000, 8'h03, 0, 8'h03, 1));
        end
        rows.push_back(mk(0, 1, 8'h00, 0, 1, 16'h0000, 8'h03, 0, 8'h00, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1000, 8'h00, 1, 8'h01, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL halt[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
        end
        mem[3] = 16'h1003;
    endtask

    task automatic test_reset_mid_stall();
        obs_t o, e;
        row_t rows[$];
        rows.push_back(mk(1, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1000, 8'h00, 1, 8'h01, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1001, 8'h01, 1, 8'h02, 0));
        rows.push_back(mk(0, 0, 8'h00, 0, 1, 16'h1002, 8'h02, 1, 8'h03, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = sb.pop_front();
            o = {instruction, pc_out, valid, imem_addr, halted};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d]: got i=%h pc=%h v=%b a=%h h=%b want i=%h pc=%h v=%b a=%h h=%b",
                         k, o.instr, o.pc, o.valid, o.addr, o.halted,
                         e.instr, e.pc, e.valid, e.addr, e.halted);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (fetch_count !== 32'(k)) begin
                failures++;
                $display("FAIL fetch_count[%0d]: got %0d want %0d", k, fetch_count, k);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h1000 + 16'(i);
        end
        reset         = 1'b1;
        pc_write_en   = 1'b1;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        #2;
        test_reset();
        test_normal();
        test_stall();
        test_branch_flush();
        test_wrap();
        test_halt();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the vector ASIP pipeline; sits directly upstream of decoderStage.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned 16-bit word into the IF/ID pipeline register whose outputs feed decoderStage.instruction.
- Handles stalls (PCWriteEn), flushes, taken branches and a HALT instruction that freezes fetch.

Parameters:
- PC_W, 8, program-counter width in bits; word addresses, one 16-bit instruction per word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_write_en  input  1  PCWriteEn; 0 = stall (hold PC and IF/ID).
- flush  input  1  replace the next IF/ID contents with a bubble.
- branch_taken  input  1  redirect fetch to branch_target.
- branch_target  input  PC_W  redirect address.
- imem_addr  output  PC_W  instruction-memory address; equals the PC register combinationally.
- imem_rdata  input  16  instruction word at imem_addr; asynchronous-read memory, valid in the same cycle.
- instruction  output  16  IF/ID instruction to the decoder.
- pc_out  output  PC_W  PC of the instruction held in IF/ID.
- valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch FSM is in FETCH_HALT.

Behaviour:
- Reset (synchronous, highest priority):
  - PC=RESET_PC, instruction=NOP_INSTR (16'h0000), pc_out=0, valid=0, halted=0, state=FETCH_RUN.
  - Reset mid-operation discards all in-flight state on that edge.
- FSM states:
  - FETCH_RUN: normal fetch.
  - FETCH_HALT: fetch frozen.
- FETCH_RUN, per edge, priority branch_taken > flush > stall > normal:
  - branch_taken=1: PC<=branch_target; IF/ID<=bubble (NOP_INSTR, valid=0, pc_out unchanged). Overrides pc_write_en=0 and flush.
  - flush=1 and pc_write_en=1: IF/ID<=bubble; PC<=PC+1.
  - flush=1 and pc_write_en=0: IF/ID<=bubble; PC held.
  - pc_write_en=0: PC, instruction, pc_out and valid all hold.
  - normal: instruction<=imem_rdata, pc_out<=PC, valid<=1, PC<=PC+1 modulo 2^PC_W (wraps from all-ones to 0, no flag).
  - imem_rdata==HALT_INSTR (16'hFFFF) on a normal edge: the word is latched into IF/ID with valid=1, PC holds, next state FETCH_HALT.
- FETCH_HALT:
  - PC holds; IF/ID<=bubble each edge; halted=1.
  - branch_taken=1: PC<=branch_target, state<=FETCH_RUN, halted<=0, IF/ID bubble.
  - flush and pc_write_en are ignored.
  - Only reset or branch_taken leaves FETCH_HALT.
- Latency: an instruction at PC appears on instruction/pc_out one edge after it is addressed.
- Branch penalty: one bubble from this stage. Older-stage bubbles are the responsibility of the hazard unit via flush.
- Bubbles: always NOP_INSTR with valid=0. decoderStage must treat NOP_INSTR as no register or memory write.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Extra output fetch_count (32 bits).
  - Incremented on every edge where IF/ID is loaded with valid=1, including the HALT word.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
  - Stalled edges do not count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package asip_pkg:
  - INSTR_W=16, NOP_INSTR=16'h0000, HALT_INSTR=16'hFFFF.
  - fetch_state_t enum {FETCH_RUN, FETCH_HALT}.
- Sub-module fetch_if_id_reg:
  - IF/ID register with inputs load, bubble, hold.
  - Contains instruction, pc_out and valid.
  - Reused pattern for later ID/EX registers.
- PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset then memory returning 16'h1000+addr for 4 cycles, pc_write_en=1 -> pc_out 0,1,2,3; instruction 16'h1000..16'h1003; valid=1 from the first edge after reset.
- pc_write_en=0 for 2 cycles at PC=5 -> PC, instruction and pc_out stable for 2 edges; resumes with pc_out=5 then 6.
- branch_taken=1, branch_target=8'h40, simultaneously with pc_write_en=0 and flush=1 -> next edge valid=0, instruction=16'h0000; following edge pc_out=8'h40.
- HALT_INSTR at address 3 -> pc_out=3, instruction=16'hFFFF, valid=1, halted=1; 5 further cycles valid=0 with PC held at 3; branch_taken to 0 -> halted=0 and fetch resumes at 0.
- PC_W=8, PC=8'hFF with normal fetch -> pc_out=8'hFF, next fetch address 8'h00.
- Reset asserted mid-stall with valid=1 -> after the edge PC=RESET_PC, valid=0, halted=0; with FETCH_PERF_CNT_EN, fetch_count=0 and it counts exactly 3 after 3 normal fetches.
